// File: rtl/meta_sync_pkg.sv
// Shared types and helpers for the metastability synchroniser and debounce filter.
// Holds the per-channel filter state encoding and the qualify-counter sizing rule.
package meta_sync_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filt_state_t;

  // Sized so that the counter can hold FILT_CYCLES without wrapping.
  function automatic int cnt_width(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/meta_sync_filter_ch.sv
// One bit line: plain flop synchroniser chain, persistence filter and registered edge pulses.
// The filter only accepts a new level after it has been seen for FILT_CYCLES consecutive cycles.
module meta_sync_filter_ch
  import meta_sync_pkg::*;
#(
  parameter int   N_STAGE     = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  localparam int               CNT_W    = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [N_STAGE-1:0] sync_q;
  logic               sync_s;
  filt_state_t        state_q;
  filt_state_t        state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               level_d;

  assign sync_s = sync_q[N_STAGE-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= {N_STAGE{RST_VAL}};
      state_q <= STABLE;
      cnt_q   <= '0;
      o_sync  <= RST_VAL;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[N_STAGE-2:0], i_async};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_sync  <= level_d;
      o_rise  <= level_d & ~o_sync;
      o_fall  <= ~level_d & o_sync;
    end
  end

  // cnt_q counts mismatch cycles already seen; the edge that would complete
  // FILT_CYCLES of them commits the new level instead of counting further.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = o_sync;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync_s != o_sync) begin
          if (FILT_CYCLES == 1) begin
            level_d = sync_s;
          end else begin
            state_d = QUALIFY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QUALIFY: begin
        if (sync_s == o_sync) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          level_d = sync_s;
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/meta_sync_filter.sv
// Multi-channel synchroniser/debouncer: N_WIDTH fully independent copies of the channel block.
// Illegal parameter values are rejected at elaboration time.
module meta_sync_filter
  import meta_sync_pkg::*;
#(
  parameter int                 N_STAGE     = 2,
  parameter int                 N_WIDTH     = 1,
  parameter int                 FILT_CYCLES = 4,
  parameter logic [N_WIDTH-1:0] RST_VAL     = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_WIDTH-1:0] i_async,
  output logic [N_WIDTH-1:0] o_sync,
  output logic [N_WIDTH-1:0] o_rise,
  output logic [N_WIDTH-1:0] o_fall
);

  if (N_STAGE < 2) begin : g_bad_stage
    $error("meta_sync_filter: N_STAGE must be at least 2");
  end

  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("meta_sync_filter: FILT_CYCLES must be at least 1");
  end

  for (genvar g = 0; g < N_WIDTH; g++) begin : g_ch
    meta_sync_filter_ch #(
      .N_STAGE    (N_STAGE),
      .FILT_CYCLES(FILT_CYCLES),
      .RST_VAL    (RST_VAL[g])
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_async(i_async[g]),
      .o_sync (o_sync[g]),
      .o_rise (o_rise[g]),
      .o_fall (o_fall[g])
    );
  end

endmodule
